// File: rtl/mandelbrot_frame_engine.sv
// Raster-scan Mandelbrot frame generator with a recirculating PIPE_DEPTH-slot ring.
// Optional build macro MANDEL_STATS_EN enables the frame_cycles / maxed_pixels counters.
module mandelbrot_frame_engine #(
    parameter int H_RES       = 32,
    parameter int V_RES       = 16,
    parameter int ADDR_WIDTH  = 9,
    parameter int ITER_WIDTH  = 8,
    parameter int COORD_WIDTH = 18,
    parameter int FRAC_BITS   = 13,
    parameter int PIPE_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ITER_WIDTH-1:0]         max_iter,
    input  logic signed [COORD_WIDTH-1:0] re_origin,
    input  logic signed [COORD_WIDTH-1:0] im_origin,
    input  logic signed [COORD_WIDTH-1:0] re_step,
    input  logic signed [COORD_WIDTH-1:0] im_step,
    output logic                          busy,
    output logic                          done,
    output logic                          we,
    output logic [ADDR_WIDTH-1:0]         waddr,
    output logic [ITER_WIDTH-1:0]         wdata,
    output logic [31:0]                   frame_cycles,
    output logic [ADDR_WIDTH:0]           maxed_pixels
);
    localparam int W  = COORD_WIDTH;
    localparam int HD = PIPE_DEPTH - 1;
    localparam logic [ADDR_WIDTH:0]   NPIX   = (ADDR_WIDTH+1)'(H_RES * V_RES);
    localparam logic [ADDR_WIDTH-1:0] X_LAST = ADDR_WIDTH'(H_RES - 1);
    localparam logic signed [2*W:0]   ESC_LIMIT = (2*W+1)'(4) << (2*FRAC_BITS);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
    state_t state_reg;

    logic [ITER_WIDTH-1:0] max_iter_reg;
    logic signed [W-1:0]   re_origin_reg, re_step_reg, im_step_reg;
    logic signed [W-1:0]   pix_re_reg, pix_im_reg;
    logic [ADDR_WIDTH-1:0] pix_x_reg;
    logic [ADDR_WIDTH:0]   issued_reg;

    logic [PIPE_DEPTH-1:0] valid_reg;
    logic [ADDR_WIDTH-1:0] addr_reg [PIPE_DEPTH];
    logic signed [W-1:0]   c_re_reg [PIPE_DEPTH];
    logic signed [W-1:0]   c_im_reg [PIPE_DEPTH];
    logic signed [W-1:0]   z_re_reg [PIPE_DEPTH];
    logic signed [W-1:0]   z_im_reg [PIPE_DEPTH];
    logic [ITER_WIDTH-1:0] n_reg    [PIPE_DEPTH];

    logic signed [2*W-1:0] re_sq, im_sq, re_im;
    logic signed [2*W:0]   mag_sq;
    logic signed [W-1:0]   z_re_next, z_im_next;
    logic                  running, escaped, retire, recirc, refill;

    // Head-slot evaluation; the doubled cross product shifts by one bit less.
    assign running   = (state_reg == ST_RUN);
    assign re_sq     = z_re_reg[HD] * z_re_reg[HD];
    assign im_sq     = z_im_reg[HD] * z_im_reg[HD];
    assign re_im     = z_re_reg[HD] * z_im_reg[HD];
    assign mag_sq    = (2*W+1)'(re_sq) + (2*W+1)'(im_sq);
    assign escaped   = (mag_sq > ESC_LIMIT);
    assign z_re_next = W'(re_sq >>> FRAC_BITS) - W'(im_sq >>> FRAC_BITS) + c_re_reg[HD];
    assign z_im_next = W'(re_im >>> (FRAC_BITS - 1)) + c_im_reg[HD];
    assign retire    = valid_reg[HD] && (escaped || (n_reg[HD] == max_iter_reg));
    assign recirc    = valid_reg[HD] && !retire;
    assign refill    = running && !recirc && (issued_reg != NPIX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                addr_reg[i] <= '0;
                c_re_reg[i] <= '0;
                c_im_reg[i] <= '0;
                z_re_reg[i] <= '0;
                z_im_reg[i] <= '0;
                n_reg[i]    <= '0;
            end
        end else begin
            for (int i = 1; i < PIPE_DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                addr_reg[i]  <= addr_reg[i-1];
                c_re_reg[i]  <= c_re_reg[i-1];
                c_im_reg[i]  <= c_im_reg[i-1];
                z_re_reg[i]  <= z_re_reg[i-1];
                z_im_reg[i]  <= z_im_reg[i-1];
                n_reg[i]     <= n_reg[i-1];
            end
            if (recirc) begin
                valid_reg[0] <= 1'b1;
                addr_reg[0]  <= addr_reg[HD];
                c_re_reg[0]  <= c_re_reg[HD];
                c_im_reg[0]  <= c_im_reg[HD];
                z_re_reg[0]  <= z_re_next;
                z_im_reg[0]  <= z_im_next;
                n_reg[0]     <= n_reg[HD] + ITER_WIDTH'(1);
            end else if (refill) begin
                valid_reg[0] <= 1'b1;
                addr_reg[0]  <= issued_reg[ADDR_WIDTH-1:0];
                c_re_reg[0]  <= pix_re_reg;
                c_im_reg[0]  <= pix_im_reg;
                z_re_reg[0]  <= '0;
                z_im_reg[0]  <= '0;
                n_reg[0]     <= '0;
            end else begin
                valid_reg[0] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            we            <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            max_iter_reg  <= '0;
            re_origin_reg <= '0;
            re_step_reg   <= '0;
            im_step_reg   <= '0;
            pix_re_reg    <= '0;
            pix_im_reg    <= '0;
            pix_x_reg     <= '0;
            issued_reg    <= '0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_RUN;
                        busy          <= 1'b1;
                        max_iter_reg  <= max_iter;
                        re_origin_reg <= re_origin;
                        re_step_reg   <= re_step;
                        im_step_reg   <= im_step;
                        pix_re_reg    <= re_origin;
                        pix_im_reg    <= im_origin;
                        pix_x_reg     <= '0;
                        issued_reg    <= '0;
                    end
                end
                ST_RUN: begin
                    // A retiring slot's n equals max_iter when it hit the limit.
                    if (retire) begin
                        we    <= 1'b1;
                        waddr <= addr_reg[HD];
                        wdata <= n_reg[HD];
                    end
                    if (refill) begin
                        issued_reg <= issued_reg + 1'b1;
                        if (pix_x_reg == X_LAST) begin
                            pix_x_reg  <= '0;
                            pix_re_reg <= re_origin_reg;
                            pix_im_reg <= pix_im_reg - im_step_reg;
                        end else begin
                            pix_x_reg  <= pix_x_reg + 1'b1;
                            pix_re_reg <= pix_re_reg + re_step_reg;
                        end
                    end
                    if ((issued_reg == NPIX) && (valid_reg == '0)) begin
                        state_reg <= ST_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef MANDEL_STATS_EN
    logic [31:0]         frame_cycles_reg;
    logic [ADDR_WIDTH:0] maxed_pixels_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cycles_reg <= '0;
            maxed_pixels_reg <= '0;
        end else if ((state_reg == ST_IDLE) && start) begin
            frame_cycles_reg <= '0;
            maxed_pixels_reg <= '0;
        end else if (running) begin
            frame_cycles_reg <= frame_cycles_reg + 32'd1;
            if (retire && !escaped)
                maxed_pixels_reg <= maxed_pixels_reg + 1'b1;
        end
    end

    assign frame_cycles = frame_cycles_reg;
    assign maxed_pixels = maxed_pixels_reg;
`else
    assign frame_cycles = '0;
    assign maxed_pixels = '0;
`endif

endmodule

// File: doc/mandelbrot_frame_engine.md
# mandelbrot_frame_engine

Parametrised Mandelbrot frame generator that scans an H_RES×V_RES pixel grid, computes each pixel's escape-iteration count in a recirculating multi-slot fixed-point pipeline, and issues one fire-and-forget write per pixel to an external frame-buffer RAM. It generalises the fixed-depth, fixed-limit generator with:

- a 2D programmable viewport;
- a runtime iteration limit;
- start/busy/done frame control;
- out-of-order retirement.

## Interface
- H_RES, 32: pixels per row.
- V_RES, 16: rows per frame; H_RES*V_RES ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 9: frame-buffer address width.
- ITER_WIDTH, 8: iteration count / write data width.
- COORD_WIDTH, 18: signed fixed-point coordinate width; COORD_WIDTH−FRAC_BITS ≥ 5.
- FRAC_BITS, 13: fractional bits.
- PIPE_DEPTH, 4: slots in the ring, ≥ 2; one iteration takes PIPE_DEPTH cycles.

Ports (reset is asynchronous, active-low):
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request, sampled only while idle.
- max_iter  in  ITER_WIDTH  iteration limit, latched at start.
- re_origin, im_origin  in  COORD_WIDTH  c of pixel (0,0), latched at start.
- re_step, im_step  in  COORD_WIDTH  per-pixel increments, latched at start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle end-of-frame pulse.
- we  out  1  write strobe.
- waddr  out  ADDR_WIDTH  y*H_RES+x.
- wdata  out  ITER_WIDTH  iteration count.
- frame_cycles  out  32  stats (see Configuration).
- maxed_pixels  out  ADDR_WIDTH+1  stats (see Configuration).

## Operation
- Idle→RUN on start: latch all configuration and clear the issue counter. Further starts are ignored until done.
- Pixel c: re = re_origin + x*re_step; im = im_origin − y*im_step. Two's-complement arithmetic, wrapped to COORD_WIDTH. Pixels are issued in raster order (x fastest).
- Per-slot state: valid, addr, c_re, c_im, z_re, z_im, n.
- Each cycle the head slot is evaluated:
  - Valid, with z_re²+z_im² > 4.0 (strict; full 2*COORD_WIDTH+1 precision, no truncation): retire with n.
  - Else valid with n == max_iter: retire with max_iter.
  - Else valid: z ← (z_re²−z_im²+c_re, 2·z_re·z_im+c_im). Each product is arithmetic-shifted right by FRAC_BITS (truncation), then wrapped to COORD_WIDTH. Then n ← n+1 and the slot recirculates.
  - Retired or invalid head: refilled with the next pixel (z=0, n=0) if pixels remain, else marked invalid.
- Products may be staged across ring stages, but results must be bit-identical to the sequential definition above.
- Retirements are out of order. Each address is written exactly once per frame, for exactly H_RES*V_RES writes; at most one write per cycle.
- RUN→DONE when all pixels are issued, all slots are invalid, and the last write has been issued. DONE lasts one cycle, then returns to idle.

## Timing
- Reset values: busy=0, done=0, we=0, waddr=0, wdata=0, stats=0; all slots invalid, state idle.
- Edge numbering: start is sampled at edge 0.
  - busy is high from after edge 0 through the final we cycle.
  - The first fill happens at edge 1.
  - A pixel filled at edge k is first evaluated at edge k+PIPE_DEPTH. Its write is visible in the cycle after its retiring edge.
  - Minimum pixel latency is PIPE_DEPTH+1 edges to we.
- we/waddr/wdata are registered. When we=0, waddr/wdata hold their last values.
- done is high for exactly the one cycle after the last we cycle, with busy=0 in that cycle. A start in the done cycle is ignored.
- Reset mid-frame: everything returns to its reset value immediately; no further writes; the next start runs a complete new frame.
- max_iter=0: every pixel retires with 0 at its first evaluation, in raster order.

## Configuration
- MANDEL_STATS_EN defined:
  - frame_cycles counts edges from start acceptance to done, and holds that value until the next start.
  - maxed_pixels counts pixels retired at max_iter.
  - Both counters clear at start.
- MANDEL_STATS_EN undefined: both ports are driven constant 0 and no counter logic is built.

## Test plan
All directed tests use H_RES=4, V_RES=2, PIPE_DEPTH=4, FRAC_BITS=13.
- Reset: hold rst_n=0 with random inputs -> all outputs 0; assert rst_n mid-frame -> we=0 and busy=0 at once, no further writes.
- max_iter=0, all origins/steps 0 -> 8 writes, addr 0..7 in order, data 0; first we after edge 5; single done pulse.
- c=3.0+0i (steps 0), max_iter=255 -> every pixel data 1; c=2.0+0i -> data 2 (|z|²=4 does not escape).
- c=0 and c=−1.0 (steps 0), max_iter=200 -> all data 200; with MANDEL_STATS_EN, maxed_pixels=8.
- re_origin=−2.0, re_step=1.0, im_origin=0.5, im_step=1.0, max_iter=50 -> out-of-order writes; each address exactly once; data matches the sequential model; done only after the 8th write.
- start pulsed while busy -> ignored (no config change, no extra writes); a start after done re-runs the frame, and frame_cycles is reproduced identically.
